// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths, state encoding and timing constants for the neuron sequencer
package nn_pkg;

    localparam int MAX_IN    = 256;
    localparam int MAX_NEU   = 64;
    localparam int W_AW      = 14;
    localparam int CNT_W     = $clog2(MAX_IN + 1);
    localparam int NEU_W     = $clog2(MAX_NEU + 1);
    localparam int DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/nn_addr_gen.sv
// rtl/nn_addr_gen.sv - input index, neuron index and weight address counters with last flags
module nn_addr_gen import nn_pkg::*; (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             k_clr_i,
    input  logic             k_inc_i,
    input  logic             neu_clr_i,
    input  logic             neu_inc_i,
    input  logic             w_clr_i,
    input  logic             w_inc_i,
    input  logic [CNT_W-1:0] cfg_n_in_i,
    input  logic [NEU_W-1:0] cfg_n_neu_i,
    output logic [CNT_W-2:0] k_addr_o,
    output logic [NEU_W-2:0] neu_addr_o,
    output logic [W_AW-1:0]  w_addr_o,
    output logic             k_last_o,
    output logic             neu_last_o
);

    logic [CNT_W-1:0] k_q;
    logic [NEU_W-1:0] neu_q;
    logic [W_AW-1:0]  w_q;

    // Per-neuron input index: cleared before each neuron, stepped once per issued read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_q <= '0;
        end else if (k_clr_i) begin
            k_q <= '0;
        end else if (k_inc_i) begin
            k_q <= k_q + CNT_W'(1);
        end
    end

    // Neuron index: cleared at layer start, stepped at each write-back
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            neu_q <= '0;
        end else if (neu_clr_i) begin
            neu_q <= '0;
        end else if (neu_inc_i) begin
            neu_q <= neu_q + NEU_W'(1);
        end
    end

    // Weight address runs continuously across neurons, so it is only cleared at layer start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_q <= '0;
        end else if (w_clr_i) begin
            w_q <= '0;
        end else if (w_inc_i) begin
            w_q <= w_q + W_AW'(1);
        end
    end

    assign k_addr_o   = k_q[CNT_W-2:0];
    assign neu_addr_o = neu_q[NEU_W-2:0];
    assign w_addr_o   = w_q;
    assign k_last_o   = (k_q + CNT_W'(1)) == cfg_n_in_i;
    assign neu_last_o = (neu_q + NEU_W'(1)) == cfg_n_neu_i;

endmodule

// File: rtl/nn_seq_ctrl.sv
// rtl/nn_seq_ctrl.sv - layer sequencer driving memories and the binarised neuron datapath
module nn_seq_ctrl import nn_pkg::*; (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cfg_n_in_i,
    input  logic [NEU_W-1:0] cfg_n_neu_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             in_rd_en_o,
    output logic [CNT_W-2:0] in_addr_o,
    input  logic             in_rdata_i,
    output logic             w_rd_en_o,
    output logic [W_AW-1:0]  w_addr_o,
    input  logic             w_rdata_i,
    output logic             dp_op_o,
    output logic             dp_a_lsb_o,
    output logic             dp_valid_o,
    output logic             dp_clr_o,
    input  logic             agg_acted_i,
    output logic             out_wr_en_o,
    output logic [NEU_W-2:0] out_addr_o,
    output logic             out_wdata_o
);

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             rd_en_q;
    logic             dp_valid_q;
    logic             dp_clr_q;
    logic             out_wr_en_q;
    logic [NEU_W-2:0] out_addr_q;
    logic             out_wdata_q;
    logic [0:0]       drain_q;
    logic [CNT_W-1:0] cfg_n_in_q;
    logic [NEU_W-1:0] cfg_n_neu_q;

    logic             abort_hit;
    logic             accept;
    logic             cfg_ok;
    logic [CNT_W-2:0] k_addr;
    logic [NEU_W-2:0] neu_addr;
    logic [W_AW-1:0]  w_addr;
    logic             k_last;
    logic             neu_last;

    assign abort_hit = abort_i && (state_q != S_IDLE);
    assign accept    = (state_q == S_IDLE) && start_i && !abort_i;
    assign cfg_ok    = (cfg_n_in_i != '0) && (cfg_n_neu_i != '0);

    nn_addr_gen u_addr_gen (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .k_clr_i     (state_q == S_CLR),
        .k_inc_i     (state_q == S_ISSUE),
        .neu_clr_i   (accept),
        .neu_inc_i   (state_q == S_WB),
        .w_clr_i     (accept),
        .w_inc_i     (state_q == S_ISSUE),
        .cfg_n_in_i  (cfg_n_in_q),
        .cfg_n_neu_i (cfg_n_neu_q),
        .k_addr_o    (k_addr),
        .neu_addr_o  (neu_addr),
        .w_addr_o    (w_addr),
        .k_last_o    (k_last),
        .neu_last_o  (neu_last)
    );

    // Sequencer FSM with registered strobes; abort from any active state returns to IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            dp_valid_q  <= 1'b0;
            dp_clr_q    <= 1'b0;
            out_wr_en_q <= 1'b0;
            out_addr_q  <= '0;
            out_wdata_q <= 1'b0;
            drain_q     <= '0;
            cfg_n_in_q  <= '0;
            cfg_n_neu_q <= '0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dp_clr_q    <= 1'b0;
            out_wr_en_q <= 1'b0;
            // Read data arrives one cycle after the strobe, so the accumulate enable trails it
            dp_valid_q  <= rd_en_q && !abort_hit;
            if (abort_hit) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                rd_en_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            if (cfg_ok) begin
                                cfg_n_in_q  <= cfg_n_in_i;
                                cfg_n_neu_q <= cfg_n_neu_i;
                                state_q     <= S_CLR;
                                busy_q      <= 1'b1;
                                dp_clr_q    <= 1'b1;
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                err_q   <= 1'b1;
                            end
                        end
                    end
                    S_CLR: begin
                        state_q <= S_ISSUE;
                        rd_en_q <= 1'b1;
                    end
                    S_ISSUE: begin
                        if (k_last) begin
                            state_q <= S_DRAIN;
                            rd_en_q <= 1'b0;
                            drain_q <= '0;
                        end
                    end
                    S_DRAIN: begin
                        if (drain_q == 1'(DRAIN_CYC - 1)) begin
                            state_q     <= S_WB;
                            out_wr_en_q <= 1'b1;
                            out_addr_q  <= neu_addr;
                            out_wdata_q <= agg_acted_i;
                        end else begin
                            drain_q <= drain_q + 1'b1;
                        end
                    end
                    S_WB: begin
                        if (neu_last) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_CLR;
                            dp_clr_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        rd_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Operands come straight from the memory output registers while the enable is up;
    // abort clears the aggregator and kills the enable in the same cycle
    always_comb begin
        dp_valid_o = dp_valid_q && !abort_hit;
        dp_clr_o   = dp_clr_q || abort_hit;
        dp_op_o    = dp_valid_o && in_rdata_i;
        dp_a_lsb_o = dp_valid_o && w_rdata_i;
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign in_rd_en_o  = rd_en_q;
    assign w_rd_en_o   = rd_en_q;
    assign in_addr_o   = rd_en_q ? k_addr : '0;
    assign w_addr_o    = rd_en_q ? w_addr : '0;
    assign out_wr_en_o = out_wr_en_q;
    assign out_addr_o  = out_addr_q;
    assign out_wdata_o = out_wdata_q;

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// tb/tb_nn_seq_ctrl.sv - scoreboard bench for the neuron layer sequencer
module tb_nn_seq_ctrl;

    localparam int CNT_W = nn_pkg::CNT_W;
    localparam int NEU_W = nn_pkg::NEU_W;
    localparam int W_AW  = nn_pkg::W_AW;
    localparam int NW    = nn_pkg::MAX_IN * nn_pkg::MAX_NEU;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] cfg_n_in = '0;
    logic [NEU_W-1:0] cfg_n_neu = '0;
    logic             abort = 1'b0;
    logic             busy, done, err;
    logic             in_rd_en, w_rd_en;
    logic [CNT_W-2:0] in_addr;
    logic [W_AW-1:0]  w_addr;
    logic             in_rdata = 1'b0;
    logic             w_rdata = 1'b0;
    logic             dp_op, dp_a_lsb, dp_valid, dp_clr;
    logic             agg_acted;
    logic             out_wr_en;
    logic [NEU_W-2:0] out_addr;
    logic             out_wdata;

    logic             in_mem [0:nn_pkg::MAX_IN-1];
    logic             w_mem  [0:NW-1];
    logic [31:0]      rd_q [$];
    logic [31:0]      wr_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc = 0;
    int cur_n_in = 1;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int clr_cnt = 0;
    logic done_err = 1'b0;

    always #5 clk = ~clk;

    nn_seq_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .cfg_n_in_i  (cfg_n_in),
        .cfg_n_neu_i (cfg_n_neu),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .in_rd_en_o  (in_rd_en),
        .in_addr_o   (in_addr),
        .in_rdata_i  (in_rdata),
        .w_rd_en_o   (w_rd_en),
        .w_addr_o    (w_addr),
        .w_rdata_i   (w_rdata),
        .dp_op_o     (dp_op),
        .dp_a_lsb_o  (dp_a_lsb),
        .dp_valid_o  (dp_valid),
        .dp_clr_o    (dp_clr),
        .agg_acted_i (agg_acted),
        .out_wr_en_o (out_wr_en),
        .out_addr_o  (out_addr),
        .out_wdata_o (out_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_rd(input int k, input int w);
        return 32'((k << 14) | w);
    endfunction

    function automatic logic [31:0] pack_wr(input int j, input logic b);
        return 32'((j << 1) | int'(b));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memories with one-cycle registered read
    always @(posedge clk) begin
        if (in_rd_en) in_rdata <= in_mem[in_addr];
        if (w_rd_en) w_rdata <= w_mem[w_addr];
    end

    // Aggregator: count of matching input/weight pairs, activated on majority
    always @(posedge clk) begin
        if (dp_clr) acc <= 0;
        else if (dp_valid) acc <= acc + ((dp_op == dp_a_lsb) ? 1 : 0);
    end
    assign agg_acted = (2 * acc >= cur_n_in);

    // Output monitor: pops scoreboard entries as strobes appear
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n) begin
            if (in_rd_en != w_rd_en) chk("rd_en_pair", 32'(in_rd_en), 32'(w_rd_en));
            if (in_rd_en) begin
                if (rd_q.size() == 0) chk("rd_unexpected", pack_rd(int'(in_addr), int'(w_addr)), 32'hffffffff);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_addr", pack_rd(int'(in_addr), int'(w_addr)), e);
                end
            end
            if (out_wr_en) begin
                if (wr_q.size() == 0) chk("wr_unexpected", pack_wr(int'(out_addr), out_wdata), 32'hffffffff);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_data", pack_wr(int'(out_addr), out_wdata), e);
                end
            end
            if (dp_clr && dp_valid) chk("clr_valid_excl", 32'(dp_clr && dp_valid), 32'd0);
            if (dp_clr) clr_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = err;
                chk("done_busy", 32'(busy), 32'd0);
            end
        end
    end

    task automatic push_layer(input int n_in, input int n_neu, input int max_rd, input int max_wr);
        int r;
        int pop;
        r = 0;
        for (int j = 0; j < n_neu; j++) begin
            pop = 0;
            for (int k = 0; k < n_in; k++) begin
                if (r < max_rd) rd_q.push_back(pack_rd(k, j * n_in + k));
                r++;
                pop += (in_mem[k] == w_mem[j * n_in + k]) ? 1 : 0;
            end
            if (j < max_wr) wr_q.push_back(pack_wr(j, (2 * pop >= n_in)));
        end
    endtask

    task automatic pulse_start(input int n_in, input int n_neu);
        @(posedge clk); #1;
        cfg_n_in  = CNT_W'(n_in);
        cfg_n_neu = NEU_W'(n_neu);
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(done_cnt != d0), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_rdq"}, 32'(rd_q.size()), 32'd0);
        chk({tag, "_wrq"}, 32'(wr_q.size()), 32'd0);
        rd_q.delete();
        wr_q.delete();
    endtask

    task automatic run_layer(input string tag, input int n_in, input int n_neu);
        logic zero;
        int clr0;
        zero = (n_in == 0 || n_neu == 0);
        clr0 = clr_cnt;
        if (!zero) push_layer(n_in, n_neu, 1 << 30, 1 << 30);
        cur_n_in = n_in;
        pulse_start(n_in, n_neu);
        wait_done(20000);
        chk({tag, "_lat"}, 32'(done_cyc - start_cyc), zero ? 32'd1 : 32'(n_neu * (n_in + 4) + 1));
        chk({tag, "_err"}, 32'(done_err), 32'(zero));
        if (zero) chk({tag, "_no_clr"}, 32'(clr_cnt - clr0), 32'd0);
        check_drained(tag);
    endtask

    task automatic fill_random();
        foreach (in_mem[i]) in_mem[i] = 1'($urandom);
        foreach (w_mem[i]) w_mem[i] = 1'($urandom);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctrl"},
            32'({busy, done, err, in_rd_en, w_rd_en, dp_op, dp_a_lsb, dp_valid, dp_clr, out_wr_en, out_wdata}),
            32'd0);
        chk({tag, "_addr"}, 32'({in_addr, w_addr, out_addr}), 32'd0);
    endtask

    initial begin
        int d0;
        foreach (in_mem[i]) in_mem[i] = 1'b1;
        foreach (w_mem[i]) w_mem[i] = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // All-ones layer: in_addr 0..3 twice, w_addr 0..7, both neurons activate
        run_layer("ones_4x2", 4, 2);

        fill_random();
        run_layer("rand_5x3", 5, 3);
        run_layer("rand_7x1", 7, 1);
        run_layer("rand_1x4", 1, 4);

        // Zero-size configurations complete immediately with err
        run_layer("zero_in", 0, 3);
        run_layer("zero_neu", 5, 0);

        // Abort in the third ISSUE cycle of neuron 1
        d0 = done_cnt;
        push_layer(8, 3, 8 + 3, 1);
        cur_n_in = 8;
        pulse_start(8, 3);
        repeat (15) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_clr", 32'(dp_clr), 32'd1);
        chk("abort_valid", 32'(dp_valid), 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check_drained("abort");

        // Abort and start together in IDLE: start is dropped
        d0 = done_cnt;
        @(posedge clk); #1;
        cfg_n_in = CNT_W'(4);
        cfg_n_neu = NEU_W'(2);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_start_no_done", 32'(done_cnt - d0), 32'd0);
        check_drained("abort_start");

        // Re-pulsed start with a different cfg while busy is ignored
        d0 = done_cnt;
        push_layer(3, 2, 1 << 30, 1 << 30);
        cur_n_in = 3;
        pulse_start(3, 2);
        repeat (3) @(posedge clk);
        #1;
        cfg_n_in = CNT_W'(6);
        cfg_n_neu = NEU_W'(4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        chk("repulse_lat", 32'(done_cyc - start_cyc), 32'(2 * (3 + 4) + 1));
        repeat (30) @(posedge clk);
        #1;
        chk("repulse_one_done", 32'(done_cnt - d0), 32'd1);
        check_drained("repulse");

        // Reset asserted in DRAIN of neuron 0 discards the layer
        d0 = done_cnt;
        push_layer(4, 2, 4, 0);
        cur_n_in = 4;
        pulse_start(4, 2);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
        check_drained("rst_mid");
        run_layer("post_rst_6x2", 6, 2);

        // Full-size layer: last w_addr is MAX_IN*MAX_NEU-1
        run_layer("max", nn_pkg::MAX_IN, nn_pkg::MAX_NEU);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
